// File: rtl/cache_axi_pkg.sv
// Shared types and constants for the cache-to-AXI4 bridge.
//   state_t        : bridge FSM states
//   AXI_BURST_INCR : AxBURST encoding for incrementing bursts
//   AXI_RESP_OKAY  : xRESP encoding for a good response
//   axi_size()     : AxSIZE encoding for a bus of the given data width
package cache_axi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AR   = 3'd1,
    ST_R    = 3'd2,
    ST_AW   = 3'd3,
    ST_W    = 3'd4,
    ST_B    = 3'd5,
    ST_DONE = 3'd6
  } state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  // AxSIZE is log2 of the number of bytes per beat.
  function automatic logic [2:0] axi_size(input int data_width);
    return 3'($clog2(data_width / 8));
  endfunction

endpackage

// File: rtl/cache_axi_perf.sv
// Performance counters for cache_axi_master (built only with CACHE_AXI_PERF_EN).
//   clk, rst_n       : clock, asynchronous active-low reset
//   clr_i            : synchronous clear of all three counters
//   ar_hs_i, aw_hs_i : one-cycle pulses on AR / AW handshakes
//   stall_i          : current state's valid is high while its partner's ready is low
//   *_o              : 32-bit saturating counts
module cache_axi_perf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr_i,
  input  logic        ar_hs_i,
  input  logic        aw_hs_i,
  input  logic        stall_i,
  output logic [31:0] rd_bursts_o,
  output logic [31:0] wr_bursts_o,
  output logic [31:0] stall_cycles_o
);

  logic [31:0] rd_q, wr_q, stall_q;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && v != '1) ? v + 32'd1 : v;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q    <= '0;
      wr_q    <= '0;
      stall_q <= '0;
    end else if (clr_i) begin
      rd_q    <= '0;
      wr_q    <= '0;
      stall_q <= '0;
    end else begin
      rd_q    <= sat_inc(rd_q, ar_hs_i);
      wr_q    <= sat_inc(wr_q, aw_hs_i);
      stall_q <= sat_inc(stall_q, stall_i);
    end
  end

  assign rd_bursts_o    = rd_q;
  assign wr_bursts_o    = wr_q;
  assign stall_cycles_o = stall_q;

endmodule

// File: rtl/cache_axi_master.sv
// Cache line refill / writeback bridge onto an AXI4 master port.
// One transaction in flight; each request is one INCR burst of LINE_BEATS
// full-width beats. Refill beats stream out on rsp_*, writeback beats are
// taken from wb_*, and done_valid pulses once with done_err at the end.
// Ports:
//   clk, rst_n                         : clock, asynchronous active-low reset
//   req_valid/ready, req_write, req_addr : line request (write=1 writeback)
//   wb_data, wb_strb, wb_valid/ready   : writeback beat stream in
//   rsp_data, rsp_last, rsp_valid/ready: refill beat stream out
//   done_valid, done_err               : completion pulse and error flag
//   m_axi_aw*/w*/b*/ar*/r*             : AXI4 master channels
// Optional feature macro: CACHE_AXI_PERF_EN adds perf_clr and the
// perf_rd_bursts / perf_wr_bursts / perf_stall_cycles counters.
module cache_axi_master
  import cache_axi_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int ID_WIDTH   = 8,
  parameter int LINE_BEATS = 8,
  parameter int RD_ID      = 0,
  parameter int WR_ID      = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   wb_data,
  input  logic [DATA_WIDTH/8-1:0] wb_strb,
  input  logic                    wb_valid,
  output logic                    wb_ready,
  output logic [DATA_WIDTH-1:0]   rsp_data,
  output logic                    rsp_last,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    done_valid,
  output logic                    done_err,
  output logic [ID_WIDTH-1:0]     m_axi_awid,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [7:0]              m_axi_awlen,
  output logic [2:0]              m_axi_awsize,
  output logic [1:0]              m_axi_awburst,
  output logic                    m_axi_awlock,
  output logic [3:0]              m_axi_awcache,
  output logic [2:0]              m_axi_awprot,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wlast,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [ID_WIDTH-1:0]     m_axi_bid,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  output logic [ID_WIDTH-1:0]     m_axi_arid,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [7:0]              m_axi_arlen,
  output logic [2:0]              m_axi_arsize,
  output logic [1:0]              m_axi_arburst,
  output logic                    m_axi_arlock,
  output logic [3:0]              m_axi_arcache,
  output logic [2:0]              m_axi_arprot,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [ID_WIDTH-1:0]     m_axi_rid,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rlast,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready
`ifdef CACHE_AXI_PERF_EN
  ,
  input  logic                    perf_clr,
  output logic [31:0]             perf_rd_bursts,
  output logic [31:0]             perf_wr_bursts,
  output logic [31:0]             perf_stall_cycles
`endif
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int CW     = $clog2(LINE_BEATS) + 1;
  localparam int OFF    = $clog2(LINE_BEATS * STRB_W);
  localparam logic [CW-1:0]         LAST_CNT   = CW'(LINE_BEATS - 1);
  localparam logic [7:0]            AXI_LEN    = 8'(LINE_BEATS - 1);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {ADDR_WIDTH{1'b1}} << OFF;
  localparam logic [ID_WIDTH-1:0]   RID        = ID_WIDTH'(RD_ID);
  localparam logic [ID_WIDTH-1:0]   WID        = ID_WIDTH'(WR_ID);

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    err_q, err_d;
  logic                    req_ready_q;
  logic [DATA_WIDTH-1:0]   rdata_hold_q, wdata_hold_q;
  logic [STRB_W-1:0]       wstrb_hold_q;

  logic beat_last, in_r, in_w;
  assign beat_last = (cnt_q == LAST_CNT);
  assign in_r      = (state_q == ST_R);
  assign in_w      = (state_q == ST_W);

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so that no
    // branch of the case below can leave it unassigned and infer a latch.
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: if (req_valid && req_ready_q) begin
        addr_d  = req_addr & ALIGN_MASK;
        cnt_d   = '0;
        err_d   = 1'b0;
        state_d = req_write ? ST_AW : ST_AR;
      end
      ST_AR: if (m_axi_arready) state_d = ST_R;
      ST_AW: if (m_axi_awready) state_d = ST_W;
      ST_R: if (m_axi_rvalid && rsp_ready) begin
        cnt_d = cnt_q + CW'(1);
        // rlast must agree with our own count; any disagreement is an error
        // but the burst is still drained to LINE_BEATS beats.
        if ((m_axi_rlast != beat_last) || (m_axi_rresp != AXI_RESP_OKAY) ||
            (m_axi_rid != RID))
          err_d = 1'b1;
        if (beat_last) state_d = ST_DONE;
      end
      ST_W: if (wb_valid && m_axi_wready) begin
        cnt_d = cnt_q + CW'(1);
        if (beat_last) state_d = ST_B;
      end
      ST_B: if (m_axi_bvalid) begin
        if ((m_axi_bresp != AXI_RESP_OKAY) || (m_axi_bid != WID)) err_d = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        err_d   = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      req_ready_q  <= 1'b0;
      // NOTE: the hold registers are plain flops, not a RAM, so resetting
      // them is free and keeps the data outputs defined straight out of reset.
      rdata_hold_q <= '0;
      wdata_hold_q <= '0;
      wstrb_hold_q <= '0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values.
      state_q     <= state_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      // Registered so req_ready only rises on the first edge after reset.
      req_ready_q <= (state_d == ST_IDLE);
      if (in_r) rdata_hold_q <= m_axi_rdata;
      if (in_w) begin
        wdata_hold_q <= wb_data;
        wstrb_hold_q <= wb_strb;
      end
    end
  end

  assign req_ready  = req_ready_q;
  assign done_valid = (state_q == ST_DONE);
  assign done_err   = (state_q == ST_DONE) && err_q;

  // Read address channel
  assign m_axi_arid    = RID;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = AXI_LEN;
  assign m_axi_arsize  = axi_size(DATA_WIDTH);
  assign m_axi_arburst = AXI_BURST_INCR;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = 4'b0000;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arvalid = (state_q == ST_AR);

  // Read data passes straight through to the cache while in R.
  assign rsp_valid    = in_r && m_axi_rvalid;
  assign m_axi_rready = in_r && rsp_ready;
  assign rsp_data     = in_r ? m_axi_rdata : rdata_hold_q;
  assign rsp_last     = in_r && beat_last;

  // Write address channel
  assign m_axi_awid    = WID;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awlen   = AXI_LEN;
  assign m_axi_awsize  = axi_size(DATA_WIDTH);
  assign m_axi_awburst = AXI_BURST_INCR;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = 4'b0000;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awvalid = (state_q == ST_AW);

  // Writeback data passes straight through while in W; wlast follows our count.
  assign m_axi_wvalid = in_w && wb_valid;
  assign wb_ready     = in_w && m_axi_wready;
  assign m_axi_wdata  = in_w ? wb_data : wdata_hold_q;
  assign m_axi_wstrb  = in_w ? wb_strb : wstrb_hold_q;
  assign m_axi_wlast  = in_w && beat_last;

  assign m_axi_bready = (state_q == ST_B);

`ifdef CACHE_AXI_PERF_EN
  logic perf_stall;
  // bready is always high in B, so B can never stall from our side.
  assign perf_stall = (m_axi_arvalid && !m_axi_arready) ||
                      (m_axi_awvalid && !m_axi_awready) ||
                      (in_r && m_axi_rvalid && !rsp_ready) ||
                      (in_w && wb_valid && !m_axi_wready);

  cache_axi_perf u_perf (
    .clk            (clk),
    .rst_n          (rst_n),
    .clr_i          (perf_clr),
    .ar_hs_i        (m_axi_arvalid && m_axi_arready),
    .aw_hs_i        (m_axi_awvalid && m_axi_awready),
    .stall_i        (perf_stall),
    .rd_bursts_o    (perf_rd_bursts),
    .wr_bursts_o    (perf_wr_bursts),
    .stall_cycles_o (perf_stall_cycles)
  );
`endif

endmodule
